// File: rtl/sync_fifo_pkg.sv
// Shared constants for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

  // Default geometry: 16 entries of 8 bits, 4-bit entry address.
  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultAddr  = 4;

  // Read-port modes.
  localparam int unsigned FwftRegistered  = 0;  // data registered on the popping edge
  localparam int unsigned FwftFallThrough = 1;  // head word shown combinationally

endpackage

// File: rtl/sync_fifo_prog_mem.sv
// Storage array for sync_fifo_prog: write-clocked, asynchronous read, no reset.
module sync_fifo_prog_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ADDR  = DefaultAddr
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ADDR-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ADDR-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds and a
// selectable registered or first-word-fall-through read port.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_PROG_ERR_EN.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ADDR  = DefaultAddr,
  parameter int unsigned FWFT  = FwftRegistered
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_winc,
  input  logic [WIDTH-1:0] i_WR_Data,
  input  logic             i_rinc,
  input  logic [ADDR:0]    i_af_thr,
  input  logic [ADDR:0]    i_ae_thr,
  output logic [WIDTH-1:0] o_RD_Data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
`ifdef SYNC_FIFO_PROG_ERR_EN
  input  logic             i_clr_err,
  output logic             o_overflow,
  output logic             o_underflow,
`endif
  output logic [ADDR:0]    o_count
);

  localparam logic [ADDR:0] FullCount = (ADDR+1)'(DEPTH);

  logic [ADDR-1:0]  wptr_q, wptr_d;
  logic [ADDR-1:0]  rptr_q, rptr_d;
  logic [ADDR:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] head_data;
  logic             wr_en, rd_en;

  // Flags come from the registered count only, so requests never feed them.
  assign o_full  = (count_q == FullCount);
  assign o_empty = (count_q == '0);

  // Full blocks writes, empty blocks reads; at full or empty a simultaneous
  // request pair therefore degenerates to the single legal operation.
  assign wr_en = i_winc & ~o_full;
  assign rd_en = i_rinc & ~o_empty;

  // Pointer and occupancy next state; pointers wrap naturally at ADDR bits.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_en) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Read data register loads the head word on a pop and holds otherwise.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = head_data;
    end
  end

  // Pointer, count and read-data state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  sync_fifo_prog_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (i_WR_Data),
    .raddr_i (rptr_q),
    .rdata_o (head_data)
  );

  // Fall-through mode exposes the head entry directly; it becomes valid the
  // cycle after a write into an empty FIFO because the array is write-clocked.
  assign o_RD_Data = (FWFT == FwftFallThrough) ? head_data : rd_data_q;

  // Thresholds are live inputs, compared unsigned against the registered count.
  assign o_almost_full  = (count_q >= i_af_thr);
  assign o_almost_empty = (count_q <= i_ae_thr);

  assign o_count = count_q;

`ifdef SYNC_FIFO_PROG_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; clear takes priority over a same-cycle set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (i_winc && o_full) begin
        overflow_d = 1'b1;
      end
      if (i_rinc && o_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Error flag state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`endif

endmodule
